ether_tx_sched: RTL and testbench
=================================

# ether_tx_sched

Transmit scheduler in front of the RMII MAC transmitter in the Ethernet interface. Buffers bus read responses in a small FIFO and shares the single MAC between that response stream and an auxiliary requester. Issues one `start_o` pulse per frame with a stable 5-byte payload. Spaces frames by a fixed frame-duration plus inter-frame-gap timer, so back-to-back reads are no longer lost while the MAC is busy.

## Interface
Parameters:
- `DEPTH`, 8: response FIFO depth in entries; power of 2, ≥2.
- `FRAME_CYCLES`, 288: clk cycles the MAC needs per frame. Default is 72 bytes at 2 bits/cycle.
- `IFG_CYCLES`, 48: idle cycles after a frame. Default is 96 bit times.
- `FAIR_LIMIT`, 4: maximum consecutive response frames while aux is waiting.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `rdata_i` in 16: bus read data.
- `rw_i` in 1: bus direction; 0 means read response.
- `valid_i` in 1: bus transaction valid.
- `aux_data_i` in 16: auxiliary payload word.
- `aux_valid_i` in 1: auxiliary request; held until accepted.
- `aux_ready_o` out 1: auxiliary accept strobe.
- `payload_o` out 40: MAC payload.
- `start_o` out 1: one-cycle MAC start pulse.
- `busy_o` out 1: high in START, FRAME or GAP.
- `fifo_count_o` out $clog2(DEPTH)+1: FIFO occupancy.
- `overflow_o` out 1: sticky; a response was dropped.

## Operation
- Push condition: `valid_i && !rw_i`. `rdata_i` is written on that edge.
- If the FIFO is full and no pop occurs that cycle, the word is dropped and `overflow_o` is set. `overflow_o` clears only on reset.
- If the FIFO is full and a pop occurs in the same cycle, the push succeeds.
- Payload format: `payload_o = {tag[7:0], 16'h0000, data[15:0]}`. Tag is 8'h00 for a response, 8'h01 for aux.
- FSM states are IDLE, START, FRAME and GAP.
- IDLE, selection rule:
  - FIFO non-empty and (`fair_cnt < FAIR_LIMIT` or `!aux_valid_i`): pop the FIFO, load `payload_o` with tag 00, increment `fair_cnt` (saturating), go to START.
  - Else if `aux_valid_i`: pulse `aux_ready_o` for this cycle, load `payload_o` with tag 01, clear `fair_cnt`, go to START.
  - Else: stay in IDLE.
- START: `start_o`=1 for exactly one cycle; go to FRAME.
- FRAME: count `FRAME_CYCLES` cycles, then go to GAP.
- GAP: count `IFG_CYCLES` cycles, then go to IDLE.
- `payload_o` is held stable from START until the next IDLE selection.
- `fair_cnt` is also cleared whenever the design is in IDLE with `aux_valid_i` low.
- The cycle timer is sized for max(`FRAME_CYCLES`, `IFG_CYCLES`). It reloads on every state entry.
- Pushes are accepted in every state.

## Timing
- Reset values: `start_o`=0, `aux_ready_o`=0, `busy_o`=0, `payload_o`=0, `fifo_count_o`=0, `overflow_o`=0. FSM is in IDLE and `fair_cnt`=0.
- Latency: a read sampled at edge N while idle and empty gives `start_o` high in cycle N+2.
  - N+1 is IDLE selection.
  - N+2 is START.
- Frame period: consecutive `start_o` pulses are exactly 1+`FRAME_CYCLES`+`IFG_CYCLES`+1 cycles apart, which is 338 at defaults.
- Aux handshake: `aux_ready_o` is high for one cycle, combinational with the IDLE selection. `aux_data_i` is sampled in that cycle. `aux_valid_i` may drop the next cycle.
- Asynchronous reset mid-frame: `start_o` falls immediately, the FIFO empties and the FSM returns to IDLE. The in-flight MAC frame is not aborted by this block.

## Configuration
- Macro `ETHER_TX_SCHED_AUX_EN`:
  - Defined: aux channel and fairness logic are present, as described above.
  - Undefined:
    - Ports remain.
    - `aux_ready_o` is tied 0 and `aux_valid_i`/`aux_data_i` are ignored.
    - `fair_cnt` is removed.
    - Only tag 00 frames are sent.

## Test plan
- Single read 16'hBEEF while idle, reset released -> `start_o` 2 cycles later with `payload_o`=40'h00_0000_BEEF. `busy_o` high for 337 cycles.
- Three reads on consecutive cycles (0x0001, 0x0002, 0x0003) -> three `start_o` pulses, 338 cycles apart, with payloads in order. `overflow_o` stays 0.
- DEPTH+2 = 10 reads pushed during one frame -> 8 stored. `fifo_count_o`=8 and `overflow_o`=1. The first 8 words are transmitted in order.
- `aux_valid_i` held with 0xA5A5 while 6 reads are queued -> 4 response frames, then an aux frame with `payload_o`=40'h01_0000_A5A5, then the remaining 2 responses.
- Reset asserted 100 cycles into FRAME with 3 queued -> outputs zero immediately. After release, no `start_o` without new input.
- Build without `ETHER_TX_SCHED_AUX_EN`, `aux_valid_i`=1 -> `aux_ready_o` stays 0. Only tag 00 frames are sent.

Source files
------------

// File: rtl/ether_tx_sched_if.sv
// ether_tx_sched_if: groups the bus-side and MAC-side signals of ether_tx_sched.
// The master modport is the side that drives read responses and aux requests
// and observes the MAC-facing results. The slave modport is the scheduler's view.
// Handshake: an aux request is presented by holding aux_valid with aux_data.
// It is taken in the single cycle where aux_ready is high. The requester may
// drop aux_valid on the following cycle. Read responses (valid && !rw) have no
// back-pressure and are either stored or dropped, which raises overflow.
interface ether_tx_sched_if #(
  parameter int DEPTH = 8
);
  logic [15:0]            rdata;
  logic                   rw;
  logic                   valid;
  logic [15:0]            aux_data;
  logic                   aux_valid;
  logic                   aux_ready;
  logic [39:0]            payload;
  logic                   start;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;

  modport master (
    output rdata, rw, valid, aux_data, aux_valid,
    input  aux_ready, payload, start, busy, fifo_count, overflow
  );

  modport slave (
    input  rdata, rw, valid, aux_data, aux_valid,
    output aux_ready, payload, start, busy, fifo_count, overflow
  );
endinterface

// File: rtl/ether_tx_sched.sv
// ether_tx_sched: transmit scheduler in front of the RMII MAC transmitter.
// Read responses are queued in a small FIFO. The single MAC is shared between
// that queue and an auxiliary requester. One start pulse is issued per frame,
// followed by a frame-duration plus inter-frame-gap hold-off.
// Optional feature macro: ETHER_TX_SCHED_AUX_EN enables the aux channel and the
// fairness counter. When it is undefined, only response frames (tag 00) are sent.
// Handshake: aux_valid_i is held until aux_ready_o pulses. aux_data_i is taken
// in that same cycle, and aux_valid_i may drop the cycle after.
module ether_tx_sched #(
  parameter int DEPTH        = 8,
  parameter int FRAME_CYCLES = 288,
  parameter int IFG_CYCLES   = 48,
  parameter int FAIR_LIMIT   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [15:0]            rdata_i,
  input  logic                   rw_i,
  input  logic                   valid_i,
  input  logic [15:0]            aux_data_i,
  input  logic                   aux_valid_i,
  output logic                   aux_ready_o,
  output logic [39:0]            payload_o,
  output logic                   start_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] fifo_count_o,
  output logic                   overflow_o
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (FRAME_CYCLES > IFG_CYCLES) ? FRAME_CYCLES : IFG_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [7:0] TAG_RESP = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_FRAME = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [39:0]    payload_q, payload_d;

  logic [15:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           overflow_q;

  logic           push;
  logic           push_ok;
  logic           pop;
  logic           full;
  logic           empty;
  logic           aux_sel;

`ifdef ETHER_TX_SCHED_AUX_EN
  localparam int FW = $clog2(FAIR_LIMIT + 1);
  localparam logic [7:0] TAG_AUX = 8'h01;
  logic [FW-1:0]  fair_q, fair_d;
`else
  // Aux inputs are accepted on the port list but have no function here.
  logic           unused_aux;
  assign unused_aux = ^{aux_valid_i, aux_data_i};
`endif

  // FIFO status. A push into a full FIFO still succeeds when the scheduler pops
  // the same cycle, because the freed slot is the one being written.
  assign push    = valid_i && !rw_i;
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && (!full || pop);

  // Next-state, selection and timer logic for the frame scheduler.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    payload_d = payload_q;
    pop       = 1'b0;
    aux_sel   = 1'b0;
`ifdef ETHER_TX_SCHED_AUX_EN
    fair_d    = fair_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef ETHER_TX_SCHED_AUX_EN
        // Fairness only counts response frames sent while aux is waiting.
        if (!aux_valid_i) fair_d = '0;
        if (!empty && ((fair_q < FW'(FAIR_LIMIT)) || !aux_valid_i)) begin
          pop       = 1'b1;
          payload_d = {TAG_RESP, 16'h0000, mem_q[rd_ptr_q]};
          // This branch with aux waiting implies fair_q < FAIR_LIMIT, so the
          // increment saturates at FAIR_LIMIT on its own.
          if (aux_valid_i) fair_d = fair_q + 1'b1;
        end else if (aux_valid_i) begin
          aux_sel   = 1'b1;
          payload_d = {TAG_AUX, 16'h0000, aux_data_i};
          fair_d    = '0;
        end
`else
        if (!empty) begin
          pop       = 1'b1;
          payload_d = {TAG_RESP, 16'h0000, mem_q[rd_ptr_q]};
        end
`endif
        if (pop || aux_sel) begin
          state_d = S_START;
          timer_d = '0;
        end
      end
      S_START: begin
        state_d = S_FRAME;
        timer_d = TW'(FRAME_CYCLES - 1);
      end
      S_FRAME: begin
        if (timer_q == '0) begin
          state_d = S_GAP;
          timer_d = TW'(IFG_CYCLES - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Scheduler state, timer and held payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      payload_q <= payload_d;
    end
  end

`ifdef ETHER_TX_SCHED_AUX_EN
  // Consecutive response frames granted while aux is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fair_q <= '0;
    else        fair_q <= fair_d;
  end
`endif

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rdata_i;
  end

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign start_o      = (state_q == S_START);
  assign busy_o       = (state_q != S_IDLE);
  assign aux_ready_o  = aux_sel;
  assign payload_o    = payload_q;
  assign fifo_count_o = count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_ether_tx_sched.sv
// tb_ether_tx_sched: self-checking bench for ether_tx_sched.
// Expected frames come from a queue model of the scheduling rules; start
// pulses and payloads seen on the DUT are collected by a monitor and compared.
module tb_ether_tx_sched;
  localparam int DEPTH        = 8;
  localparam int FRAME_CYCLES = 288;
  localparam int IFG_CYCLES   = 48;
  localparam int FAIR_LIMIT   = 4;
  localparam int PERIOD       = 1 + FRAME_CYCLES + IFG_CYCLES + 1;
  localparam int BUSY_LEN     = 1 + FRAME_CYCLES + IFG_CYCLES;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ether_tx_sched_if #(.DEPTH(DEPTH)) bus ();

  ether_tx_sched #(
    .DEPTH(DEPTH), .FRAME_CYCLES(FRAME_CYCLES),
    .IFG_CYCLES(IFG_CYCLES), .FAIR_LIMIT(FAIR_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rdata_i(bus.rdata), .rw_i(bus.rw), .valid_i(bus.valid),
    .aux_data_i(bus.aux_data), .aux_valid_i(bus.aux_valid),
    .aux_ready_o(bus.aux_ready), .payload_o(bus.payload),
    .start_o(bus.start), .busy_o(bus.busy),
    .fifo_count_o(bus.fifo_count), .overflow_o(bus.overflow)
  );

  // ---------------- monitor ----------------
  int          st_cyc_q[$];
  logic [39:0] st_pay_q[$];
  int          aux_rdy_cnt = 0;
  always @(negedge clk) begin
    if (bus.start) begin
      st_cyc_q.push_back(cyc);
      st_pay_q.push_back(bus.payload);
    end
    if (bus.aux_ready) aux_rdy_cnt++;
  end

  // ---------------- scoreboard ----------------
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [39:0] exp_q[$];

  function automatic logic [39:0] resp_frame(input logic [15:0] d);
    return {8'h00, 16'h0000, d};
  endfunction

  function automatic logic [39:0] aux_frame(input logic [15:0] d);
    return {8'h01, 16'h0000, d};
  endfunction

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus.valid = 1'b0; bus.rw = 1'b1; bus.rdata = '0;
    bus.aux_valid = 1'b0; bus.aux_data = '0;
  endtask

  task automatic apply_reset();
    #1 rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic push_word(input logic [15:0] d);
    @(posedge clk); #1;
    bus.valid = 1'b1; bus.rw = 1'b0; bus.rdata = d;
  endtask

  task automatic bus_write(input logic [15:0] d);
    @(posedge clk); #1;
    bus.valid = 1'b1; bus.rw = 1'b1; bus.rdata = d;
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.rw = 1'b1;
  endtask

  task automatic wait_starts(input int n_abs, input int budget, output bit ok);
    int b = budget;
    while (st_cyc_q.size() < n_abs && b > 0) begin
      @(posedge clk); b--;
    end
    ok = (st_cyc_q.size() >= n_abs);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int b = budget;
    @(negedge clk);
    while (bus.busy && b > 0) begin
      @(negedge clk); b--;
    end
    ok = !bus.busy;
  endtask

  // Compare collected frames starting at base against exp_q, including spacing.
  task automatic check_frames(input string name, input int base, input bit ok);
    vec_cnt++;
    if (!ok) begin
      err_cnt++;
      $display("FAIL %s_count: got %0d frames want %0d", name, st_cyc_q.size() - base, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        vec_cnt++;
        if (st_pay_q[base+i] !== exp_q[i]) begin
          err_cnt++;
          $display("FAIL %s_payload[%0d]: got %h want %h", name, i, st_pay_q[base+i], exp_q[i]);
        end
        if (i > 0) begin
          vec_cnt++;
          if (st_cyc_q[base+i] - st_cyc_q[base+i-1] !== PERIOD) begin
            err_cnt++;
            $display("FAIL %s_period[%0d]: got %0d want %0d", name, i,
                     st_cyc_q[base+i] - st_cyc_q[base+i-1], PERIOD);
          end
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int base;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_cnt++; if (bus.start !== 1'b0) begin err_cnt++; $display("FAIL rst_start: got %b want 0", bus.start); end
    vec_cnt++; if (bus.aux_ready !== 1'b0) begin err_cnt++; $display("FAIL rst_aux_ready: got %b want 0", bus.aux_ready); end
    vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    vec_cnt++; if (bus.payload !== 40'h0) begin err_cnt++; $display("FAIL rst_payload: got %h want 0", bus.payload); end
    vec_cnt++; if (bus.fifo_count !== '0) begin err_cnt++; $display("FAIL rst_fifo_count: got %0d want 0", bus.fifo_count); end
    vec_cnt++; if (bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL rst_overflow: got %b want 0", bus.overflow); end
    base = st_cyc_q.size();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    vec_cnt++; if (st_cyc_q.size() !== base) begin err_cnt++; $display("FAIL rst_idle_start: got %0d starts want 0", st_cyc_q.size() - base); end
  endtask

  task automatic test_single();
    int base, e, n;
    bit ok;
    base = st_cyc_q.size();
    push_word(16'hBEEF); e = cyc;
    idle_bus();
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
      else if (n > 0) break;
    end
    ok = (st_cyc_q.size() == base + 1);
    vec_cnt++;
    if (!ok) begin
      err_cnt++; $display("FAIL single_count: got %0d starts want 1", st_cyc_q.size() - base);
    end else begin
      vec_cnt++; if (st_cyc_q[base] !== e + 2) begin err_cnt++; $display("FAIL single_latency: got %0d want %0d", st_cyc_q[base] - e, 2); end
      vec_cnt++; if (st_pay_q[base] !== 40'h00_0000_BEEF) begin err_cnt++; $display("FAIL single_payload: got %h want 0000_00BEEF", st_pay_q[base]); end
    end
    vec_cnt++; if (n !== BUSY_LEN) begin err_cnt++; $display("FAIL single_busy_len: got %0d want %0d", n, BUSY_LEN); end
  endtask

  task automatic test_back_to_back();
    int base, e;
    bit ok;
    base = st_cyc_q.size();
    exp_q.delete();
    push_word(16'h0001); e = cyc;
    push_word(16'h0002);
    push_word(16'h0003);
    idle_bus();
    for (int i = 1; i <= 3; i++) exp_q.push_back(resp_frame(16'(i)));
    @(negedge clk);
    // three words in, the first already taken by the IDLE selection
    vec_cnt++; if (bus.fifo_count !== 2) begin err_cnt++; $display("FAIL b2b_fifo_count: got %0d want 2", bus.fifo_count); end
    wait_starts(base + 3, 3 * PERIOD + 50, ok);
    check_frames("b2b", base, ok);
    if (ok) begin
      vec_cnt++; if (st_cyc_q[base] !== e + 2) begin err_cnt++; $display("FAIL b2b_latency: got %0d want 2", st_cyc_q[base] - e); end
    end
    vec_cnt++; if (bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL b2b_overflow: got %b want 0", bus.overflow); end
    wait_idle(2 * PERIOD, ok);
  endtask

  task automatic test_overflow();
    int base, occ, dropped;
    logic [15:0] w;
    bit ok;
    apply_reset();
    base = st_cyc_q.size();
    exp_q.delete();
    w = 16'($urandom);
    push_word(w); idle_bus();
    exp_q.push_back(resp_frame(w));
    wait_starts(base + 1, 50, ok);
    repeat (10) @(posedge clk);
    occ = 0; dropped = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = 16'($urandom);
      push_word(w);
      if (occ < DEPTH) begin occ++; exp_q.push_back(resp_frame(w)); end
      else dropped++;
    end
    idle_bus();
    @(negedge clk);
    vec_cnt++; if (bus.fifo_count !== occ) begin err_cnt++; $display("FAIL ovf_fifo_count: got %0d want %0d", bus.fifo_count, occ); end
    vec_cnt++; if (bus.overflow !== (dropped > 0)) begin err_cnt++; $display("FAIL ovf_flag: got %b want %b", bus.overflow, dropped > 0); end
    wait_starts(base + exp_q.size(), exp_q.size() * PERIOD + 50, ok);
    check_frames("ovf", base, ok);
    wait_idle(2 * PERIOD, ok);
    vec_cnt++; if (bus.overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    apply_reset();
    vec_cnt++; if (bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
  endtask

`ifdef ETHER_TX_SCHED_AUX_EN
  task automatic test_fairness();
    int base, abase, b, fc;
    logic [15:0] w[6];
    logic [15:0] rq[$];
    bit aux_pend, ok;
    apply_reset();
    base = st_cyc_q.size(); abase = aux_rdy_cnt;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin w[i] = 16'($urandom); rq.push_back(w[i]); end
    push_word(w[0]);
    push_word(w[1]);
    bus.aux_valid = 1'b1; bus.aux_data = 16'hA5A5;
    for (int i = 2; i < 6; i++) push_word(w[i]);
    idle_bus();
    // Reference: aux is waiting from the first selection and all six words
    // are queued before the second selection.
    fc = 0; aux_pend = 1'b1;
    while (rq.size() > 0 || aux_pend) begin
      if (rq.size() > 0 && (fc < FAIR_LIMIT || !aux_pend)) begin
        exp_q.push_back(resp_frame(rq.pop_front()));
        fc = aux_pend ? fc + 1 : 0;
      end else begin
        exp_q.push_back(aux_frame(16'hA5A5));
        aux_pend = 1'b0; fc = 0;
      end
    end
    b = 8 * PERIOD;
    while (st_cyc_q.size() < base + exp_q.size() && b > 0) begin
      @(negedge clk); b--;
      if (bus.aux_ready && bus.aux_valid) begin
        @(posedge clk); #1 bus.aux_valid = 1'b0;
      end
    end
    ok = (st_cyc_q.size() >= base + exp_q.size());
    check_frames("fair", base, ok);
    vec_cnt++; if (aux_rdy_cnt - abase !== 1) begin err_cnt++; $display("FAIL fair_aux_ready_pulses: got %0d want 1", aux_rdy_cnt - abase); end
    wait_idle(2 * PERIOD, ok);
  endtask
`else
  task automatic test_aux_disabled();
    int base, abase;
    logic [15:0] w0, w1;
    bit ok;
    apply_reset();
    base = st_cyc_q.size(); abase = aux_rdy_cnt;
    exp_q.delete();
    bus.aux_valid = 1'b1; bus.aux_data = 16'($urandom);
    repeat (20) @(posedge clk);
    vec_cnt++; if (st_cyc_q.size() !== base) begin err_cnt++; $display("FAIL noaux_idle_start: got %0d starts want 0", st_cyc_q.size() - base); end
    w0 = 16'($urandom); w1 = 16'($urandom);
    push_word(w0); push_word(w1); idle_bus();
    exp_q.push_back(resp_frame(w0));
    exp_q.push_back(resp_frame(w1));
    wait_starts(base + 2, 2 * PERIOD + 50, ok);
    check_frames("noaux", base, ok);
    vec_cnt++; if (aux_rdy_cnt - abase !== 0) begin err_cnt++; $display("FAIL noaux_aux_ready: got %0d pulses want 0", aux_rdy_cnt - abase); end
    wait_idle(2 * PERIOD, ok);
    bus.aux_valid = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_frame();
    int base;
    bit ok;
    apply_reset();
    base = st_cyc_q.size();
    for (int i = 0; i < 4; i++) push_word(16'($urandom));
    idle_bus();
    wait_starts(base + 1, 50, ok);
    repeat (100) @(posedge clk);
    @(negedge clk);
    vec_cnt++; if (bus.fifo_count !== 3) begin err_cnt++; $display("FAIL midrst_pre_count: got %0d want 3", bus.fifo_count); end
    vec_cnt++; if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL midrst_pre_busy: got %b want 1", bus.busy); end
    #1 rst_n = 1'b0;
    #1;
    vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    vec_cnt++; if (bus.start !== 1'b0) begin err_cnt++; $display("FAIL midrst_start: got %b want 0", bus.start); end
    vec_cnt++; if (bus.payload !== 40'h0) begin err_cnt++; $display("FAIL midrst_payload: got %h want 0", bus.payload); end
    vec_cnt++; if (bus.fifo_count !== '0) begin err_cnt++; $display("FAIL midrst_fifo_count: got %0d want 0", bus.fifo_count); end
    vec_cnt++; if (bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL midrst_overflow: got %b want 0", bus.overflow); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    base = st_cyc_q.size();
    repeat (2 * PERIOD) @(posedge clk);
    vec_cnt++; if (st_cyc_q.size() !== base) begin err_cnt++; $display("FAIL midrst_no_start: got %0d starts want 0", st_cyc_q.size() - base); end
  endtask

  task automatic test_random();
    int base, e, k;
    logic [15:0] w;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      base = st_cyc_q.size();
      exp_q.delete();
      k = $urandom_range(1, DEPTH);
      e = -1;
      for (int i = 0; i < k; i++) begin
        w = 16'($urandom);
        push_word(w);
        if (e < 0) e = cyc;
        exp_q.push_back(resp_frame(w));
        // bus writes in between must never be queued
        for (int g = $urandom_range(0, 2); g > 0; g--) bus_write(16'($urandom));
      end
      idle_bus();
      wait_starts(base + k, k * PERIOD + 100, ok);
      check_frames($sformatf("rand%0d", r), base, ok);
      if (ok) begin
        vec_cnt++; if (st_cyc_q[base] !== e + 2) begin err_cnt++; $display("FAIL rand%0d_latency: got %0d want 2", r, st_cyc_q[base] - e); end
      end
      vec_cnt++; if (bus.overflow !== 1'b0) begin err_cnt++; $display("FAIL rand%0d_overflow: got %b want 0", r, bus.overflow); end
      wait_idle(2 * PERIOD, ok);
      vec_cnt++; if (!ok) begin err_cnt++; $display("FAIL rand%0d_idle: busy still %b", r, bus.busy); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
`ifdef ETHER_TX_SCHED_AUX_EN
    test_fairness();
`else
    test_aux_disabled();
`endif
    test_reset_mid_frame();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
